// File: rtl/move_sequencer_pkg.sv
// Shared constants and FSM state encoding for the move sequencer.
package move_sequencer_pkg;
    localparam int DATA_WIDTH = 16;
    localparam logic [DATA_WIDTH-1:0] IMM_DEVICE = '0;

    typedef enum logic [2:0] {
        S_SDEV  = 3'd0,
        S_SADDR = 3'd1,
        S_TDEV  = 3'd2,
        S_TADDR = 3'd3,
        S_READ  = 3'd4,
        S_WRITE = 3'd5
    } state_t;
endpackage

// File: rtl/move_sequencer_if.sv
// Instruction stream, device read/write channels and status of the move sequencer.
interface move_sequencer_if;
    import move_sequencer_pkg::*;

    logic                  ir_valid;
    logic [DATA_WIDTH-1:0] ir;
    logic                  ir_ready;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] rd_device;
    logic [DATA_WIDTH-1:0] rd_address;
    logic                  rd_ack;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req;
    logic [DATA_WIDTH-1:0] wr_device;
    logic [DATA_WIDTH-1:0] wr_address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ack;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  ir_valid, ir, rd_ack, rd_data, wr_ack,
        output ir_ready, rd_req, rd_device, rd_address,
               wr_req, wr_device, wr_address, wr_data, busy, done, err
    );

    modport slave (
        output ir_valid, ir, rd_ack, rd_data, wr_ack,
        input  ir_ready, rd_req, rd_device, rd_address,
               wr_req, wr_device, wr_address, wr_data, busy, done, err
    );
endinterface

// File: rtl/move_sequencer_xfer_timer.sv
// Saturating wait counter for the read/write phases; expired flags the last allowed cycle.
module xfer_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && run && (count_q == LAST);
endmodule

// File: rtl/move_sequencer.sv
// Fetches a four-word move instruction, reads one word from the source device
// (or takes it as immediate data) and writes it to the target device.
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    move_sequencer_if.master bus
);
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] src_dev_q, src_addr_q, dst_dev_q, dst_addr_q, data_q;
    logic                  done_q, err_q, done_d, err_d;
    logic                  fetching, accept, timer_clear, timer_run, expired;

    assign fetching  = (state_q == S_SDEV) || (state_q == S_SADDR) ||
                       (state_q == S_TDEV) || (state_q == S_TADDR);
    assign accept    = bus.ir_valid && fetching;
    assign timer_run = (state_q == S_READ) || (state_q == S_WRITE);

    xfer_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SDEV;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // An ack in the expiry cycle takes priority over the timeout abort.
    always_comb begin
        state_d     = state_q;
        timer_clear = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_SDEV:  if (accept) state_d = S_SADDR;
            S_SADDR: if (accept) state_d = S_TDEV;
            S_TDEV:  if (accept) state_d = S_TADDR;
            S_TADDR: begin
                if (accept) begin
                    state_d     = (src_dev_q == IMM_DEVICE) ? S_WRITE : S_READ;
                    timer_clear = 1'b1;
                end
            end
            S_READ: begin
                if (bus.rd_ack) begin
                    state_d     = S_WRITE;
                    timer_clear = 1'b1;
                end else if (expired) begin
                    state_d = S_SDEV;
                    err_d   = 1'b1;
                end
            end
            S_WRITE: begin
                if (bus.wr_ack) begin
                    state_d = S_SDEV;
                    done_d  = 1'b1;
                end else if (expired) begin
                    state_d = S_SDEV;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_SDEV;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_dev_q  <= '0;
            src_addr_q <= '0;
            dst_dev_q  <= '0;
            dst_addr_q <= '0;
            data_q     <= '0;
        end else begin
            if (accept) begin
                case (state_q)
                    S_SDEV:  src_dev_q <= bus.ir;
                    S_SADDR: begin
                        src_addr_q <= bus.ir;
                        if (src_dev_q == IMM_DEVICE) data_q <= bus.ir;
                    end
                    S_TDEV:  dst_dev_q  <= bus.ir;
                    S_TADDR: dst_addr_q <= bus.ir;
                    default: ;
                endcase
            end
            if ((state_q == S_READ) && bus.rd_ack) data_q <= bus.rd_data;
        end
    end

    assign bus.ir_ready   = fetching;
    assign bus.busy       = (state_q != S_SDEV);
    assign bus.rd_req     = (state_q == S_READ);
    assign bus.wr_req     = (state_q == S_WRITE);
    assign bus.rd_device  = src_dev_q;
    assign bus.rd_address = src_addr_q;
    assign bus.wr_device  = dst_dev_q;
    assign bus.wr_address = dst_addr_q;
    assign bus.wr_data    = data_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: device responder, monitor and directed moves.
module tb_move_sequencer;
    localparam int TO = 4;

    typedef struct { logic [15:0] dev; logic [15:0] addr; logic [15:0] data; } xfer_t;
    typedef struct { int kind; int lat; } end_t;   // kind 0 = done, 1 = err

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    xfer_t exp_rd[$];
    xfer_t exp_wr[$];
    end_t  exp_end[$];

    int          rd_delay;
    int          wr_delay;
    logic [15:0] rd_val;

    move_sequencer_if bus ();

    move_sequencer #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Device model: ack after a programmable number of request cycles (-1 = never).
    initial begin
        int rd_cnt;
        int wr_cnt;
        rd_cnt = 0;
        wr_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            rd_cnt       = bus.rd_req ? rd_cnt + 1 : 0;
            wr_cnt       = bus.wr_req ? wr_cnt + 1 : 0;
            bus.rd_ack   = bus.rd_req && (rd_delay >= 0) && (rd_cnt == rd_delay + 1);
            bus.wr_ack   = bus.wr_req && (wr_delay >= 0) && (wr_cnt == wr_delay + 1);
            bus.rd_data  = bus.rd_ack ? rd_val : 16'h0;
        end
    end

    // Monitor: compares bus transactions and completions against the queues.
    initial begin
        int    widx;
        int    first_acc;
        int    rd_run;
        int    last_rd_run;
        xfer_t x;
        end_t  e;
        widx = 0; first_acc = 0; rd_run = 0; last_rd_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                widx   = 0;
                rd_run = 0;
                continue;
            end
            if (bus.rd_req) rd_run++;
            else begin
                if (rd_run > 0) last_rd_run = rd_run;
                rd_run = 0;
            end
            if (bus.rd_req && exp_rd.size() == 0) check("rd_unexp", 32'(bus.rd_req), 32'd0);
            if (bus.wr_req && exp_wr.size() == 0) check("wr_unexp", 32'(bus.wr_req), 32'd0);
            if (bus.rd_req && bus.rd_ack && exp_rd.size() > 0) begin
                x = exp_rd.pop_front();
                check("rd_device", 32'(bus.rd_device), 32'(x.dev));
                check("rd_address", 32'(bus.rd_address), 32'(x.addr));
            end
            if (bus.wr_req && bus.wr_ack && exp_wr.size() > 0) begin
                x = exp_wr.pop_front();
                check("wr_device", 32'(bus.wr_device), 32'(x.dev));
                check("wr_address", 32'(bus.wr_address), 32'(x.addr));
                check("wr_data", 32'(bus.wr_data), 32'(x.data));
            end
            if (bus.done && bus.err) check("done_and_err", 32'd1, 32'd0);
            if (bus.done || bus.err) begin
                if (exp_end.size() == 0) begin
                    check("end_unexp", {31'd0, bus.done}, {31'd0, bus.err});
                    check("end_unexp_err", {31'd0, bus.err}, 32'd0);
                end else begin
                    e = exp_end.pop_front();
                    check("end_kind", 32'(bus.err), 32'(e.kind));
                    if (e.lat >= 0) check("latency", 32'(cyc - first_acc), 32'(e.lat));
                    check("end_ir_ready", 32'(bus.ir_ready), 32'd1);
                    check("end_busy", 32'(bus.busy), 32'd0);
                    if (bus.err) begin
                        if (exp_rd.size() > 0) void'(exp_rd.pop_front());
                        check("to_rd_cycles", 32'(last_rd_run), 32'(TO));
                    end
                end
            end
            if (bus.ir_valid && bus.ir_ready) begin
                if (widx == 0) first_acc = cyc;
                widx = (widx + 1) % 4;
            end
        end
    end

    task automatic send_word(input logic [15:0] w);
        int  n;
        logic acc;
        n = 0;
        bus.ir_valid = 1'b1;
        bus.ir       = w;
        forever begin
            @(negedge clk);
            acc = bus.ir_ready;
            @(posedge clk);
            #2;
            if (acc) break;
            n++;
            if (n > 60) begin
                check("ir_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        bus.ir_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit chk_rdy);
        bus.ir_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_rdy) check("stall_ir_ready", 32'(bus.ir_ready), 32'd1);
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_move(input logic [15:0] s, input logic [15:0] sa,
                             input logic [15:0] t, input logic [15:0] ta,
                             input logic [15:0] data, input int kind,
                             input int lat, input bit stall);
        xfer_t x;
        end_t  e;
        if (s != 16'h0) begin
            x.dev = s; x.addr = sa; x.data = 16'h0;
            exp_rd.push_back(x);
        end
        if (kind == 0) begin
            x.dev = t; x.addr = ta; x.data = data;
            exp_wr.push_back(x);
        end
        e.kind = kind; e.lat = lat;
        exp_end.push_back(e);
        if (stall) begin
            send_word(s);  idle(2, 1'b1);
            send_word(sa); idle(1, 1'b1);
            send_word(t);
            send_word(ta);
        end else begin
            send_word(s); send_word(sa); send_word(t); send_word(ta);
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while ((exp_end.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (exp_end.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
            check("move_pending", 32'(exp_end.size() + exp_wr.size() + exp_rd.size()), 32'd0);
            exp_end.delete(); exp_wr.delete(); exp_rd.delete();
        end
        idle(2, 1'b0);
    endtask

    initial begin
        int n;
        total = 0; bad = 0;
        rst_n = 1'b0;
        bus.ir_valid = 1'b0; bus.ir = 16'h0;
        bus.rd_ack = 1'b0; bus.rd_data = 16'h0; bus.wr_ack = 1'b0;
        rd_delay = 0; wr_delay = 0; rd_val = 16'h0;

        repeat (2) @(negedge clk);
        check("rst_ir_ready", 32'(bus.ir_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rd_req", 32'(bus.rd_req), 32'd0);
        check("rst_wr_req", 32'(bus.wr_req), 32'd0);
        check("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(1, 1'b1);

        // Normal move with slow acks
        rd_delay = 2; wr_delay = 1; rd_val = 16'hBEEF;
        send_move(16'h0003, 16'h0010, 16'h0005, 16'h0020, 16'hBEEF, 0, 9, 1'b0);
        wait_end();

        // Normal move, minimum latency
        rd_delay = 0; wr_delay = 0; rd_val = 16'h5A5A;
        send_move(16'h0011, 16'h00AA, 16'h0012, 16'h00BB, 16'h5A5A, 0, 6, 1'b0);
        wait_end();

        // Immediate move
        send_move(16'h0000, 16'h1234, 16'h0007, 16'h0002, 16'h1234, 0, 5, 1'b0);
        wait_end();

        // Stalled instruction stream
        rd_delay = 1; rd_val = 16'hC001;
        send_move(16'h0004, 16'h0044, 16'h0008, 16'h0088, 16'hC001, 0, 10, 1'b1);
        wait_end();

        // Back-to-back moves: second accepted alongside the first done
        rd_delay = 0; wr_delay = 0; rd_val = 16'h0F0F;
        send_move(16'h0021, 16'h0031, 16'h0022, 16'h0032, 16'h0F0F, 0, 6, 1'b0);
        send_move(16'h0000, 16'hCAFE, 16'h0009, 16'h0099, 16'hCAFE, 0, 5, 1'b0);
        wait_end();

        // Read timeout
        rd_delay = -1;
        send_move(16'h0006, 16'h0066, 16'h0007, 16'h0077, 16'h0000, 1, 8, 1'b0);
        wait_end();

        // Acks in the expiry cycle
        rd_delay = 3; wr_delay = 0; rd_val = 16'h7777;
        send_move(16'h0001, 16'h0101, 16'h0002, 16'h0202, 16'h7777, 0, 9, 1'b0);
        wait_end();
        rd_delay = 0; wr_delay = 3;
        send_move(16'h0000, 16'h4321, 16'h000A, 16'h000B, 16'h4321, 0, 8, 1'b0);
        wait_end();

        // Asynchronous reset in the write phase
        wr_delay = -1;
        send_move(16'h0000, 16'h1111, 16'h0002, 16'h0022, 16'h1111, 0, -1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wr_req && n < 20);
        check("pre_rst_wr_req", 32'(bus.wr_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_wr_req", 32'(bus.wr_req), 32'd0);
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_ir_ready", 32'(bus.ir_ready), 32'd1);
        exp_end.delete(); exp_wr.delete(); exp_rd.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_delay = 0; rd_delay = 1; rd_val = 16'hD00D;
        idle(1, 1'b1);
        send_move(16'h0013, 16'h0133, 16'h0014, 16'h0144, 16'hD00D, 0, 7, 1'b0);
        wait_end();
        idle(4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Executes one move instruction at a time, delivered as four consecutive instruction words: source device, source address, target device, target address.
- Reads one data word from the source device over the device read channel, then writes it to the target device over the device write channel.
- Sits between the instruction stream and the shared device bus.
- Source device ID 0 is the immediate device: the source-address word itself is the data, and no read is issued.

Parameters:
DATA_WIDTH, 16, width of instruction words, device IDs, addresses and data
TIMEOUT, 64, max cycles spent waiting for rd_ack or wr_ack; 0 disables the timeout
IMM_DEVICE, 0, source device ID meaning "immediate data"

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ir_valid  in  1  instruction word valid
ir  in  DATA_WIDTH  instruction word
ir_ready  out  1  sequencer accepts ir this cycle
rd_req  out  1  read request to device bus
rd_device  out  DATA_WIDTH  read device ID
rd_address  out  DATA_WIDTH  read address
rd_ack  in  1  read complete, rd_data valid this cycle
rd_data  in  DATA_WIDTH  read data
wr_req  out  1  write request to device bus
wr_device  out  DATA_WIDTH  write device ID
wr_address  out  DATA_WIDTH  write address
wr_data  out  DATA_WIDTH  write data
wr_ack  in  1  write complete
busy  out  1  high in every state except S_SDEV
done  out  1  one-cycle pulse when a move completes
err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, rst_n low):
  - State goes to S_SDEV.
  - All registers (src_dev, src_addr, dst_dev, dst_addr, data, timer) clear to 0.
  - done=0, err=0, rd_req=0, wr_req=0, busy=0, ir_ready=1.
  - Reset asserted mid-transfer drops rd_req/wr_req immediately; no done or err is generated.
- Word accept:
  - A word is accepted when ir_valid && ir_ready.
  - ir_ready=1 only in S_SDEV, S_SADDR, S_TDEV, S_TADDR.
- States and transitions (advance only on word accept unless stated):
  - S_SDEV: capture src_dev -> S_SADDR.
  - S_SADDR: capture src_addr.
    - If src_dev==IMM_DEVICE, also load data=ir.
    - -> S_TDEV.
  - S_TDEV: capture dst_dev -> S_TADDR.
  - S_TADDR: capture dst_addr.
    - If src_dev==IMM_DEVICE -> S_WRITE, else -> S_READ.
  - S_READ: rd_req=1; rd_device=src_dev, rd_address=src_addr, held stable.
    - rd_ack: data<=rd_data, -> S_WRITE.
  - S_WRITE: wr_req=1; wr_device=dst_dev, wr_address=dst_addr, wr_data=data, held stable.
    - wr_ack: -> S_SDEV, done=1 in the following cycle.
  - Unused encodings -> S_SDEV.
- Request outputs:
  - rd_req and wr_req are pure decodes of the state register, with no combinational path from any input.
  - rd_device/rd_address/wr_device/wr_address/wr_data are driven from registers in all states; their values outside S_READ/S_WRITE are don't-care.
- Ack sampling:
  - An ack is sampled in any cycle its request is high, including the first cycle.
  - Acks arriving while the matching request is low are ignored.
- Timer:
  - Clears on entry to S_READ or S_WRITE and increments each cycle spent there.
  - If TIMEOUT!=0 and the timer reaches TIMEOUT-1 without an ack, the next state is S_SDEV and err pulses the following cycle.
  - An ack in the same cycle as expiry wins: no err, normal transition.
  - Timer width is ceil(log2(TIMEOUT+1)); it saturates and never wraps.
- Latency:
  - Minimum 6 cycles from first word accept to done (4 accepts, 1 read, 1 write).
  - Immediate move: minimum 5 cycles.
- Throughput: the next instruction's first word is accepted in the cycle after the wr_ack cycle, concurrent with the done pulse.
- ir_valid low stalls the sequencer in its current fetch state indefinitely. Words are never dropped or duplicated.
- done and err are mutually exclusive.

Decomposition:
- Shared package/define file holds:
  - DATA_WIDTH
  - state encodings S_SDEV..S_WRITE (3-bit)
  - IMM_DEVICE
- One sub-module: xfer_timer.
  - Parameter TIMEOUT; inputs clk, rst_n, clear, run; output expired.
  - The top-level FSM uses expired for the timeout transition.

Test Plan:
- Normal move: words 0x0003,0x0010,0x0005,0x0020 back-to-back; rd_ack 2 cycles after rd_req with rd_data=0xBEEF; wr_ack after 1 cycle.
  -> rd 3/0x10, then wr 5/0x20/0xBEEF, done once, err=0.
- Immediate move: words 0x0000,0x1234,0x0007,0x0002.
  -> rd_req never asserted; wr 7/0x0002/0x1234; done 5 cycles after first accept when wr_ack is immediate.
- Stalls: ir_valid toggling 1,0,0,1,0,1,1.
  -> exactly 4 words captured in order; ir_ready stays 1 during the stall cycles.
- Timeout: TIMEOUT=4, rd_ack never asserted.
  -> rd_req high exactly 4 cycles, then err pulse, state S_SDEV, no wr_req, no done.
- Ack at expiry: TIMEOUT=4, wr_ack on the 4th wr_req cycle.
  -> done=1, err=0.
- Async reset mid-S_WRITE: rst_n low for half a cycle.
  -> wr_req falls without waiting for a clock edge; after release the sequencer accepts a fresh 4-word move correctly; done not pulsed for the aborted move.
